// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: op codes and arithmetic helpers shared by counter_bank
package counter_bank_pkg;

   localparam int MAX_N = 256;
   localparam int MAX_W = 64;

   typedef enum logic [2:0] {OP_NONE, OP_CLR, OP_NEXT, OP_PREV, OP_INC, OP_DEC} op_e;

   typedef struct packed {
      logic [MAX_W-1:0] value;
      logic             limit;
   } upd_t;

   function automatic logic [MAX_N-1:0] onehot(input int unsigned idx, input int unsigned n);
      return (idx < n) ? {{(MAX_N-1){1'b0}}, 1'b1} << idx : '0;
   endfunction

   // One extra bit holds the carry/borrow; w selects the counter width.
   function automatic upd_t step_update(input logic [MAX_W-1:0] val, input logic [MAX_W-1:0] step,
                                        input logic dir, input logic sat, input int unsigned w);
      logic [MAX_W:0] mask;
      logic [MAX_W:0] r;
      upd_t           u;
      mask    = ({{MAX_W{1'b0}}, 1'b1} << w) - (MAX_W+1)'(1);
      r       = dir ? {1'b0, val} + {1'b0, step} : {1'b0, val} - {1'b0, step};
      u.limit = dir ? (r > mask) : r[MAX_W];
      u.value = (sat && u.limit) ? (dir ? mask[MAX_W-1:0] : '0) : r[MAX_W-1:0] & mask[MAX_W-1:0];
      return u;
   endfunction

endpackage

// File: rtl/counter_bank_btn_edge_sync.sv
// btn_edge_sync: 2-flop synchroniser with a one-cycle rising-edge pulse
module btn_edge_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_i,
   output logic pulse_o
);

   logic s1_q, s2_q, prev_q;

   always_ff @(posedge clk) begin
      if (!reset_n) {s1_q, s2_q, prev_q} <= '0;
      else {s1_q, s2_q, prev_q} <= {btn_i, s1_q, s2_q};
   end

   assign pulse_o = s2_q & ~prev_q;

endmodule

// File: rtl/counter_bank.sv
// counter_bank: N front-panel counters driven by synchronised buttons plus a host load port
module counter_bank
   import counter_bank_pkg::*;
#(
   parameter  int N        = 8,
   parameter  int W        = 16,
   parameter  int STEP     = 1,
   parameter  int SATURATE = 0,
   localparam int IDX_W    = (N > 2) ? $clog2(N) : 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             btn_next,
   input  logic             btn_prev,
   input  logic             btn_inc,
   input  logic             btn_dec,
   input  logic             btn_clr,
   input  logic             load_en,
   input  logic [IDX_W-1:0] load_idx,
   input  logic [W-1:0]     load_val,
   output logic [N*W-1:0]   cntr_all,
   output logic [W-1:0]     cntr_sel,
   output logic [IDX_W-1:0] sel_idx,
   output logic [N-1:0]     sel_onehot,
   output logic             limit_pulse
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);
   localparam logic [IDX_W:0]   N_L  = (IDX_W+1)'(N);

   logic [4:0]       btn, pulse;
   op_e              op;
   logic [W-1:0]     cnt_q [N];
   logic [W-1:0]     cnt_d [N];
   logic [IDX_W-1:0] sel_q, sel_d;
   logic [W-1:0]     cntr_sel_q, cntr_sel_d;
   logic             lim_q, lim_d, ld_hit, blk;
   upd_t             upd;
   logic [MAX_N-1:0] oh_full;
   logic             unused_ok;

   // Bit order doubles as priority order: clr, next, prev, inc, dec.
   assign btn = {btn_dec, btn_inc, btn_prev, btn_next, btn_clr};

   for (genvar g = 0; g < 5; g++) begin : g_sync
      btn_edge_sync u_sync (.clk(clk), .reset_n(reset_n), .btn_i(btn[g]), .pulse_o(pulse[g]));
   end

   for (genvar g = 0; g < N; g++) begin : g_out
      assign cntr_all[g*W +: W] = cnt_q[g];
   end

   always_comb begin
      op = pulse[0] ? OP_CLR : pulse[1] ? OP_NEXT : pulse[2] ? OP_PREV :
           pulse[3] ? OP_INC : pulse[4] ? OP_DEC : OP_NONE;
      ld_hit = load_en && ({1'b0, load_idx} < N_L);
      blk = ld_hit && (load_idx == sel_q);
      upd = step_update(MAX_W'(cnt_q[sel_q]), MAX_W'(STEP), op == OP_INC, SATURATE != 0, W);
      cnt_d = cnt_q;
      sel_d = sel_q;
      lim_d = 1'b0;
      if (op == OP_NEXT) sel_d = (sel_q == LAST) ? '0 : sel_q + IDX_W'(1);
      else if (op == OP_PREV) sel_d = (sel_q == '0) ? LAST : sel_q - IDX_W'(1);
      else if (op == OP_CLR && !blk) cnt_d[sel_q] = '0;
      else if ((op == OP_INC || op == OP_DEC) && !blk) begin
         cnt_d[sel_q] = upd.value[W-1:0];
         lim_d = upd.limit;
      end
      if (ld_hit) cnt_d[load_idx] = load_val;
      cntr_sel_d = cnt_d[sel_d];
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q      <= '{default: '0};
         sel_q      <= '0;
         cntr_sel_q <= '0;
         lim_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         cntr_sel_q <= cntr_sel_d;
         lim_q      <= lim_d;
      end
   end

   assign oh_full     = onehot(32'(sel_q), N);
   assign sel_onehot  = oh_full[N-1:0];
   assign unused_ok   = ^{oh_full, upd};
   assign cntr_sel    = cntr_sel_q;
   assign sel_idx     = sel_q;
   assign limit_pulse = lim_q;

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank: directed + random scoreboard bench for wrapping and saturating counter_bank builds
module tb_counter_bank;

   localparam int N = 8;
   localparam int W = 16;
   localparam int STEP = 1;
   localparam int M = 1 << W;
   localparam logic [4:0] B_CLR = 5'h01, B_NEXT = 5'h02, B_PREV = 5'h04, B_INC = 5'h08, B_DEC = 5'h10;

   typedef struct packed {
      logic [N*W-1:0] all0, all1;
      logic [W-1:0]   cs0, cs1;
      logic [2:0]     sel;
      logic [N-1:0]   oh;
      logic           l0, l1;
   } exp_t;

   logic           clk = 0, reset_n = 0;
   logic [4:0]     btn = '0;
   logic           load_en = 0;
   logic [2:0]     load_idx = '0;
   logic [W-1:0]   load_val = '0;
   logic [N*W-1:0] all_o [2];
   logic [W-1:0]   csel_o [2];
   logic [2:0]     sidx_o [2];
   logic [N-1:0]   oh_o [2];
   logic           lim_o [2];

   int         cnt [2][N];
   int         sel = 0;
   bit         lim [2];
   logic [4:0] hist [3] = '{default: '0};
   exp_t       sb [$];
   exp_t       me;
   int         n_cmp = 0, n_bad = 0;
   int         lp [2];

   counter_bank #(.N(N), .W(W), .STEP(STEP), .SATURATE(0)) u_wrap (
      .clk(clk), .reset_n(reset_n), .btn_next(btn[1]), .btn_prev(btn[2]), .btn_inc(btn[3]),
      .btn_dec(btn[4]), .btn_clr(btn[0]), .load_en(load_en), .load_idx(load_idx), .load_val(load_val),
      .cntr_all(all_o[0]), .cntr_sel(csel_o[0]), .sel_idx(sidx_o[0]), .sel_onehot(oh_o[0]),
      .limit_pulse(lim_o[0]));

   counter_bank #(.N(N), .W(W), .STEP(STEP), .SATURATE(1)) u_sat (
      .clk(clk), .reset_n(reset_n), .btn_next(btn[1]), .btn_prev(btn[2]), .btn_inc(btn[3]),
      .btn_dec(btn[4]), .btn_clr(btn[0]), .load_en(load_en), .load_idx(load_idx), .load_val(load_val),
      .cntr_all(all_o[1]), .cntr_sel(csel_o[1]), .sel_idx(sidx_o[1]), .sel_onehot(oh_o[1]),
      .limit_pulse(lim_o[1]));

   always #5 clk = ~clk;

   task automatic cmp(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: a rising edge seen at edge k acts at edge k+2; one action per edge by priority.
   task automatic model_step();
      logic [4:0] p;
      bit         hit, blk;
      int         v;
      exp_t       e;
      if (!reset_n) begin
         for (int s = 0; s < 2; s++) for (int i = 0; i < N; i++) cnt[s][i] = 0;
         sel = 0;
         lim = '{0, 0};
         hist = '{default: '0};
      end else begin
         p = hist[1] & ~hist[2];
         hist[2] = hist[1];
         hist[1] = hist[0];
         hist[0] = btn;
         lim = '{0, 0};
         hit = load_en && load_idx < N;
         blk = hit && load_idx == sel;
         if (p[0]) begin
            if (!blk) for (int s = 0; s < 2; s++) cnt[s][sel] = 0;
         end else if (p[1]) sel = (sel + 1) % N;
         else if (p[2]) sel = (sel + N - 1) % N;
         else if ((p[3] || p[4]) && !blk) begin
            for (int s = 0; s < 2; s++) begin
               v = p[3] ? cnt[s][sel] + STEP : cnt[s][sel] - STEP;
               if (v >= M) begin
                  lim[s] = 1;
                  cnt[s][sel] = (s == 1) ? M - 1 : v - M;
               end else if (v < 0) begin
                  lim[s] = 1;
                  cnt[s][sel] = (s == 1) ? 0 : v + M;
               end else cnt[s][sel] = v;
            end
         end
         if (hit) for (int s = 0; s < 2; s++) cnt[s][load_idx] = int'(load_val);
      end
      for (int i = 0; i < N; i++) begin
         e.all0[i*W +: W] = W'(cnt[0][i]);
         e.all1[i*W +: W] = W'(cnt[1][i]);
      end
      e.cs0 = W'(cnt[0][sel]);
      e.cs1 = W'(cnt[1][sel]);
      e.sel = 3'(sel);
      e.oh  = N'(1) << sel;
      e.l0  = lim[0];
      e.l1  = lim[1];
      sb.push_back(e);
   endtask

   task automatic cycle(input logic [4:0] b = '0, input logic le = 0, input int li = 0,
                        input int lv = 0, input logic rn = 1);
      @(negedge clk);
      btn = b;
      load_en = le;
      load_idx = 3'(li);
      load_val = W'(lv);
      reset_n = rn;
      @(posedge clk);
      model_step();
   endtask

   task automatic press(input logic [4:0] m, input int reps = 1);
      repeat (reps) begin
         cycle(m);
         cycle(m);
         repeat (4) begin
            cycle();
            #1;
            lp[0] += int'(lim_o[0]);
            lp[1] += int'(lim_o[1]);
         end
      end
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         me = sb.pop_front();
         cmp("cntr_all_wrap", all_o[0], me.all0);
         cmp("cntr_all_sat", all_o[1], me.all1);
         cmp("cntr_sel_wrap", csel_o[0], me.cs0);
         cmp("cntr_sel_sat", csel_o[1], me.cs1);
         cmp("sel_idx", sidx_o[0], me.sel);
         cmp("sel_idx_sat", sidx_o[1], me.sel);
         cmp("sel_onehot", oh_o[0], me.oh);
         cmp("limit_wrap", lim_o[0], me.l0);
         cmp("limit_sat", lim_o[1], me.l1);
      end
   end

   initial begin
      logic [4:0] rb = '0;
      int         lv;
      repeat (3) cycle('0, 0, 0, 0, 0);
      #1;
      cmp("rst_sel", sidx_o[0], 0);
      cmp("rst_onehot", oh_o[0], 8'h01);
      cmp("rst_all", all_o[1], 0);
      cmp("rst_csel", csel_o[0], 0);
      cmp("rst_limit", lim_o[0], 0);

      press(B_NEXT, 3);
      cmp("next3_sel", sidx_o[0], 3);
      cmp("next3_onehot", oh_o[0], 8'h08);
      press(B_PREV, 4);
      cmp("prev4_sel", sidx_o[0], 7);
      cmp("prev4_onehot", oh_o[0], 8'h80);

      press(B_NEXT, 3);
      press(B_INC, 5);
      cmp("inc5_all", all_o[0], 128'(5) << 32);
      cmp("inc5_csel", csel_o[0], 5);
      press(B_CLR);
      cmp("clr_all", all_o[0], 0);

      press(B_NEXT, 6);
      lp = '{0, 0};
      press(B_DEC);
      cmp("dec_wrap", all_o[0][15:0], 16'hFFFF);
      cmp("dec_clamp", all_o[1][15:0], 0);
      cmp("dec_lp_wrap", lp[0], 1);
      cmp("dec_lp_sat", lp[1], 1);
      cycle('0, 1, 0, 'hFFFF);
      lp = '{0, 0};
      press(B_INC);
      cmp("inc_wrap", all_o[0][15:0], 0);
      cmp("inc_clamp", all_o[1][15:0], 16'hFFFF);
      cmp("inc_lp_wrap", lp[0], 1);
      cmp("inc_lp_sat", lp[1], 1);

      cycle('0, 1, 0, 0);
      cycle(B_INC);
      #1 cmp("hold_edge_k", all_o[0][15:0], 0);
      cycle(B_INC);
      #1 cmp("hold_edge_k1", all_o[0][15:0], 0);
      cycle(B_INC);
      #1 cmp("hold_edge_k2", all_o[0][15:0], 1);
      repeat (47) cycle(B_INC);
      repeat (4) cycle();
      #1 cmp("hold_once", all_o[0][15:0], 1);

      press(B_NEXT, 5);
      cycle(B_INC);
      cycle(B_INC);
      cycle(B_INC, 1, 5, 'h1234);
      repeat (4) cycle();
      cmp("load_wins", all_o[0][5*W +: W], 16'h1234);
      cmp("load_wins_csel", csel_o[1], 16'h1234);
      press(B_PREV);
      cycle('0, 1, 5, 0);
      cycle(B_INC);
      cycle(B_INC);
      cycle(B_INC, 1, 5, 'h1234);
      repeat (4) cycle();
      cmp("load_other", all_o[0][5*W +: W], 16'h1234);
      cmp("inc_other", all_o[0][4*W +: W], 1);

      cycle('0, 1, 4, 7);
      press(B_CLR | B_INC);
      cmp("clr_prio", all_o[0][4*W +: W], 0);

      cycle('0, 1, 4, 9);
      cycle(B_INC);
      cycle(B_INC, 0, 0, 0, 0);
      cycle('0, 0, 0, 0, 0);
      repeat (4) cycle();
      cmp("midrst_all", all_o[0], 0);
      cmp("midrst_sel", sidx_o[0], 0);
      cmp("midrst_onehot", oh_o[0], 8'h01);
      cmp("midrst_csel", csel_o[1], 0);

      repeat (3000) begin
         if ($urandom_range(0, 3) == 0) rb = 5'($urandom);
         case ($urandom_range(0, 3))
            0: lv = 0;
            1: lv = 'hFFFF;
            default: lv = int'($urandom_range(0, M - 1));
         endcase
         cycle(rb, $urandom_range(0, 9) == 0, int'($urandom_range(0, N - 1)), lv,
               $urandom_range(0, 299) != 0);
      end
      repeat (3) cycle();
      #2 cmp("sb_drain", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
